// File: rtl/cpu_ctrl_if.sv
// Bus bundle tying cpu_ctrl to its program ROM read port, the external ALU and the output consumer.
interface cpu_ctrl_if;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       mem_ack;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       halted;

    modport master (
        output mem_addr, mem_rd, alu_op, alu_a, alu_b, out_data, out_valid, halted,
        input  mem_data, mem_ack, alu_y, out_ready
    );

    modport slave (
        input  mem_addr, mem_rd, alu_op, alu_a, alu_b, out_data, out_valid, halted,
        output mem_data, mem_ack, alu_y, out_ready
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit and A/B register file for the 8-bit CPU: fetches and decodes
// instruction bytes, drives the external ALU and emits OUT values on a valid/ready port.
module cpu_ctrl #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    cpu_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_IMM,
        S_OUT,
        S_HALT
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_pc;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [2:0] r_ir;
    logic [7:0] r_outData;
    logic       r_outValid;
    logic       w_memRd;
    logic [2:0] w_aluOp;
    logic       w_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START:  w_next = S_FETCH;
            S_FETCH:  if (bus.mem_ack) w_next = S_DECODE;
            S_DECODE: begin
                if (!r_ir[2])      w_next = S_EXEC;
                else if (!r_ir[1]) w_next = S_IMM;
                else if (!r_ir[0]) w_next = S_OUT;
                else               w_next = S_HALT;
            end
            S_EXEC:   w_next = S_FETCH;
            S_IMM:    if (bus.mem_ack) w_next = S_FETCH;
            S_OUT:    if (bus.out_ready) w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_START;
        endcase
    end

    // Only EXEC hands the real opcode to the ALU; everywhere else it idles as MOV A.
    always_comb begin
        w_memRd  = 1'b0;
        w_aluOp  = 3'b100;
        w_halted = 1'b0;
        case (r_state)
            S_FETCH: w_memRd  = 1'b1;
            S_IMM:   w_memRd  = 1'b1;
            S_EXEC:  w_aluOp  = r_ir;
            S_HALT:  w_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= PC_RESET;
            r_a        <= 8'h00;
            r_b        <= 8'h00;
            r_ir       <= 3'b000;
            r_outData  <= 8'h00;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        r_ir <= bus.mem_data[7:5];
                        r_pc <= r_pc + 8'd1;
                    end
                end
                S_DECODE: begin
                    if (r_ir == 3'b110) begin
                        r_outData  <= r_a;
                        r_outValid <= 1'b1;
                    end
                end
                S_EXEC: r_a <= bus.alu_y;
                S_IMM: begin
                    // The low opcode bit picks the destination: 100 loads A, 101 loads B.
                    if (bus.mem_ack) begin
                        if (r_ir[0]) r_b <= bus.mem_data;
                        else         r_a <= bus.mem_data;
                        r_pc <= r_pc + 8'd1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) r_outValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = r_pc;
    assign bus.mem_rd    = w_memRd;
    assign bus.alu_op    = w_aluOp;
    assign bus.alu_a     = r_a;
    assign bus.alu_b     = r_b;
    assign bus.out_data  = r_outData;
    assign bus.out_valid = r_outValid;
    assign bus.halted    = w_halted;

endmodule
